// File: rtl/pixel_mixer_n.sv
// Row pixel mixer: sweeps the row's columns across the tile and sprite engines and selects
// the frontmost opaque pixel per column. Each column is written to the rowbuffer two cycles after its address.
module pixel_mixer_n #(
    parameter int NUM_TILE_LAYERS = 2,
    parameter int ROW_PIXELS      = 320,
    parameter int COLOR_W         = 4,
    parameter int PAL_W           = 4,
    localparam int AW = $clog2(ROW_PIXELS),
    localparam int PW = COLOR_W + PAL_W,
    localparam int SW = $clog2(NUM_TILE_LAYERS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          done,
    input  logic [NUM_TILE_LAYERS:0]      layer_en,
    output logic [AW-1:0]                 pixel_addr,
    input  logic [NUM_TILE_LAYERS*PW-1:0] tile_pixel_data,
    input  logic [PW-1:0]                 sp_pixel_data,
    input  logic [SW-1:0]                 sp_prio,
    output logic                          rb_wr_en,
    output logic [AW-1:0]                 rb_wr_addr,
    output logic [PW+SW-1:0]              rb_wr_data,
    output logic                          mix_done
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, WAIT_LOW} state_t;

    localparam logic [AW-1:0] LAST_COL = AW'(ROW_PIXELS - 1);

    state_t                   state, state_nxt;
    logic [NUM_TILE_LAYERS:0] mask;
    logic                     vld_d1;   // engine data on the inputs belongs to col_d1
    logic [AW-1:0]            col_d1;

    logic [COLOR_W-1:0] mix_color;
    logic [PAL_W-1:0]   mix_pal;
    logic [SW-1:0]      mix_src;
    logic               sp_opaque;

    assign sp_opaque = mask[NUM_TILE_LAYERS] && (sp_pixel_data[COLOR_W-1:0] != '0);

    // Later assignments land in front: the sprite is tried just before the tile at its level.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mix_color = '0;
        mix_pal   = '0;
        mix_src   = '0;
        for (int i = 0; i < NUM_TILE_LAYERS; i++) begin
            if (sp_opaque && sp_prio == SW'(i)) begin
                mix_color = sp_pixel_data[COLOR_W-1:0];
                mix_pal   = sp_pixel_data[PW-1:COLOR_W];
                mix_src   = SW'(NUM_TILE_LAYERS);
            end
            if (mask[i] && tile_pixel_data[i*PW +: COLOR_W] != '0) begin
                mix_color = tile_pixel_data[i*PW +: COLOR_W];
                mix_pal   = tile_pixel_data[i*PW+COLOR_W +: PAL_W];
                mix_src   = SW'(i);
            end
        end
        if (sp_opaque && 32'(sp_prio) >= NUM_TILE_LAYERS) begin
            mix_color = sp_pixel_data[COLOR_W-1:0];
            mix_pal   = sp_pixel_data[PW-1:COLOR_W];
            mix_src   = SW'(NUM_TILE_LAYERS);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (done) state_nxt = SWEEP;
            SWEEP:    if (pixel_addr == LAST_COL) state_nxt = DRAIN;
            DRAIN:    if (vld_d1 && col_d1 == LAST_COL) state_nxt = WAIT_LOW;
            WAIT_LOW: if (!done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
            mask       <= '0;
            vld_d1     <= 1'b0;
            col_d1     <= '0;
            rb_wr_en   <= 1'b0;
            rb_wr_addr <= '0;
            rb_wr_data <= '0;
            mix_done   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            if (state == IDLE && done) begin
                mask       <= layer_en;
                pixel_addr <= '0;
            end else if (state == SWEEP && pixel_addr != LAST_COL) begin
                pixel_addr <= pixel_addr + AW'(1);
            end
            vld_d1   <= (state == SWEEP);
            col_d1   <= pixel_addr;
            rb_wr_en <= vld_d1;
            mix_done <= vld_d1 && (col_d1 == LAST_COL);
            if (vld_d1) begin
                rb_wr_addr <= col_d1;
                rb_wr_data <= {mix_color, mix_pal, mix_src};
            end
        end
    end

endmodule

// File: tb/tb_pixel_mixer_n.sv
// Self-checking bench for pixel_mixer_n: a default instance (2 layers, 320 columns) and a small one
// (3 layers, 8 columns), each fed by registered engine models and checked against a layer-ranking model.
`timescale 1ns/1ps
module tb_pixel_mixer_n;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        logic [7:0] t0, t1, sp;
        logic [1:0] prio;
        logic [2:0] en;
        logic [3:0] c, p;
        logic [1:0] s;
    } dcase_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // default instance
    logic        done_a = 1'b0;
    logic [2:0]  len_a = 3'b111;
    logic [8:0]  paddr_a;
    logic [15:0] tile_a = '0;
    logic [7:0]  sp_a = '0;
    logic [1:0]  prio_a = '0;
    logic        wr_en_a, md_out_a;
    logic [8:0]  wr_addr_a;
    logic [9:0]  wr_data_a;
    logic [15:0] tmem_a [320];
    logic [7:0]  smem_a [320];
    wr_t         wq_a [$];
    int          md_a = 0, mdcyc_a = 0;

    // small instance
    logic        done_b = 1'b0;
    logic [3:0]  len_b = 4'b1111;
    logic [2:0]  paddr_b;
    logic [23:0] tile_b = '0;
    logic [7:0]  sp_b = '0;
    logic [1:0]  prio_b = '0;
    logic        wr_en_b, md_out_b;
    logic [2:0]  wr_addr_b;
    logic [9:0]  wr_data_b;
    logic [23:0] tmem_b [8];
    logic [7:0]  smem_b [8];
    wr_t         wq_b [$];
    int          md_b = 0, mdcyc_b = 0;

    pixel_mixer_n dut_a (
        .clk(clk), .rst_n(rst_n), .done(done_a), .layer_en(len_a), .pixel_addr(paddr_a),
        .tile_pixel_data(tile_a), .sp_pixel_data(sp_a), .sp_prio(prio_a),
        .rb_wr_en(wr_en_a), .rb_wr_addr(wr_addr_a), .rb_wr_data(wr_data_a), .mix_done(md_out_a)
    );

    pixel_mixer_n #(.NUM_TILE_LAYERS(3), .ROW_PIXELS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .done(done_b), .layer_en(len_b), .pixel_addr(paddr_b),
        .tile_pixel_data(tile_b), .sp_pixel_data(sp_b), .sp_prio(prio_b),
        .rb_wr_en(wr_en_b), .rb_wr_addr(wr_addr_b), .rb_wr_data(wr_data_b), .mix_done(md_out_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engines: pixel data for an address appears the cycle after it is issued.
    always @(posedge clk) begin
        tile_a <= tmem_a[paddr_a];
        sp_a   <= smem_a[paddr_a];
        tile_b <= tmem_b[paddr_b];
        sp_b   <= smem_b[paddr_b];
    end

    always @(negedge clk) begin
        if (wr_en_a) wq_a.push_back('{int'(wr_addr_a), int'(wr_data_a), cyc});
        if (md_out_a) begin md_a++; mdcyc_a = cyc; end
        if (wr_en_b) wq_b.push_back('{int'(wr_addr_b), int'(wr_data_b), cyc});
        if (md_out_b) begin md_b++; mdcyc_b = cyc; end
    end

    // Tile i sits at level 2i+1, the sprite at level 2*min(prio,n); highest opaque level wins.
    function automatic logic [9:0] ref_pix(input int nl, input logic [23:0] tiles, input logic [7:0] sp,
                                           input logic [3:0] mask, input int prio);
        int best = -1;
        int src = 0;
        int sp_lvl;
        logic [3:0] c = '0;
        logic [3:0] p = '0;
        for (int i = 0; i < nl; i++) begin
            if (mask[i] && tiles[i*8 +: 4] != 4'd0 && 2*i+1 > best) begin
                best = 2*i+1; c = tiles[i*8 +: 4]; p = tiles[i*8+4 +: 4]; src = i;
            end
        end
        sp_lvl = 2 * ((prio < nl) ? prio : nl);
        if (mask[nl] && sp[3:0] != 4'd0 && sp_lvl > best) begin
            c = sp[3:0]; p = sp[7:4]; src = nl;
        end
        return {c, p, 2'(src)};
    endfunction

    function automatic logic [7:0] rnd_pix();
        logic [7:0] v = 8'($urandom);
        if ($urandom_range(0, 2) == 0) v[3:0] = 4'd0;
        return v;
    endfunction

    task automatic fill_random(input bit sel);
        if (sel) begin
            for (int k = 0; k < 8; k++) begin
                tmem_b[k] = {rnd_pix(), rnd_pix(), rnd_pix()};
                smem_b[k] = rnd_pix();
            end
        end else begin
            for (int k = 0; k < 320; k++) begin
                tmem_a[k] = {rnd_pix(), rnd_pix()};
                smem_a[k] = rnd_pix();
            end
        end
    endtask

    task automatic run_row(input bit sel, input int max_cycles, input bit hold_full, input int toggle_at,
                           input logic [3:0] toggle_val, output int base, output int mdbase, output int start);
        @(negedge clk);
        base   = sel ? wq_b.size() : wq_a.size();
        mdbase = sel ? md_b : md_a;
        start  = cyc;
        if (sel) done_b = 1'b1; else done_a = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (c == toggle_at) begin
                if (sel) len_b = toggle_val; else len_a = toggle_val[2:0];
            end
            if (!hold_full && (sel ? md_b : md_a) != mdbase) break;
            @(negedge clk);
        end
        done_a = 1'b0;
        done_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_row(input bit sel, input string name, input int base, input int mdbase, input int start,
                             input logic [3:0] mask, input int prio, input bit use_const, input logic [9:0] kexp);
        int   cols = sel ? 8 : 320;
        int   n = (sel ? wq_b.size() : wq_a.size()) - base;
        int   mds = (sel ? md_b : md_a) - mdbase;
        wr_t  w;
        logic [9:0] exp;
        vectors++;
        if (n != cols) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d want %0d", name, n, cols);
        end
        vectors++;
        if (mds != 1) begin
            miscompares++;
            $display("FAIL %s mix_done_pulses: got %0d want 1", name, mds);
        end
        if (n > 0) begin
            w = sel ? wq_b[base] : wq_a[base];
            vectors++;
            if (w.cyc != start + 3) begin
                miscompares++;
                $display("FAIL %s first_write_cycle: got %0d want %0d", name, w.cyc, start + 3);
            end
            w = sel ? wq_b[base+n-1] : wq_a[base+n-1];
            vectors++;
            if (w.cyc != (sel ? mdcyc_b : mdcyc_a)) begin
                miscompares++;
                $display("FAIL %s mix_done_align: last write cycle %0d, pulse cycle %0d", name, w.cyc,
                         sel ? mdcyc_b : mdcyc_a);
            end
        end
        for (int k = 0; k < n && k < cols; k++) begin
            w = sel ? wq_b[base+k] : wq_a[base+k];
            if (use_const) exp = kexp;
            else if (sel)  exp = ref_pix(3, tmem_b[k], smem_b[k], mask, prio);
            else           exp = ref_pix(2, {8'h00, tmem_a[k]}, smem_a[k], mask, prio);
            vectors++;
            if (w.addr != k || w.data != int'(exp)) begin
                miscompares++;
                $display("FAIL %s col%0d: got addr %0d data 0x%03h want addr %0d data 0x%03h",
                         name, k, w.addr, w.data, k, exp);
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        vectors++;
        if (paddr_a !== '0 || wr_en_a !== 1'b0 || wr_addr_a !== '0 || wr_data_a !== '0 || md_out_a !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got addr %0d en %b wr_addr %0d data 0x%03h done %b want all zero",
                     name, paddr_a, wr_en_a, wr_addr_a, wr_data_a, md_out_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_held");
        vectors++;
        if (wr_en_b !== 1'b0 || paddr_b !== '0) begin
            miscompares++;
            $display("FAIL reset_held_small: got en %b addr %0d want 0 0", wr_en_b, paddr_b);
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_outputs_zero("idle_without_done");
        vectors++;
        if (wq_a.size() != 0) begin
            miscompares++;
            $display("FAIL idle_writes: got %0d want 0", wq_a.size());
        end
    endtask

    task automatic test_full_row_hold();
        int base, mdb, st, pr;
        fill_random(0);
        pr = $urandom_range(0, 3);
        len_a = 3'b111; prio_a = 2'(pr);
        run_row(0, 400, 1, -1, 4'h0, base, mdb, st);
        check_row(0, "hold_400", base, mdb, st, 4'h7, pr, 0, '0);
    endtask

    task automatic test_random_rows();
        int base, mdb, st, pr;
        logic [2:0] m;
        for (int r = 0; r < 4; r++) begin
            fill_random(0);
            pr = $urandom_range(0, 3);
            m = 3'($urandom);
            len_a = m; prio_a = 2'(pr);
            run_row(0, 400, 0, -1, 4'h0, base, mdb, st);
            check_row(0, $sformatf("random_row%0d", r), base, mdb, st, {1'b0, m}, pr, 0, '0);
        end
    endtask

    task automatic test_priority_directed();
        dcase_t cs [7];
        int base, mdb, st;
        cs[0] = '{8'h35, 8'h00, 8'h7A, 2'd1, 3'b111, 4'hA, 4'h7, 2'd2};
        cs[1] = '{8'h35, 8'h12, 8'h7A, 2'd2, 3'b111, 4'hA, 4'h7, 2'd2};
        cs[2] = '{8'h35, 8'h12, 8'h7A, 2'd1, 3'b111, 4'h2, 4'h1, 2'd1};
        cs[3] = '{8'h30, 8'h40, 8'h70, 2'd1, 3'b111, 4'h0, 4'h0, 2'd0};
        cs[4] = '{8'h35, 8'h12, 8'h7A, 2'd1, 3'b000, 4'h0, 4'h0, 2'd0};
        cs[5] = '{8'h35, 8'h00, 8'h7A, 2'd0, 3'b111, 4'h5, 4'h3, 2'd0};
        cs[6] = '{8'h35, 8'h12, 8'h7A, 2'd3, 3'b011, 4'h2, 4'h1, 2'd1};
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 320; k++) begin
                tmem_a[k] = {cs[i].t1, cs[i].t0};
                smem_a[k] = cs[i].sp;
            end
            len_a = cs[i].en; prio_a = cs[i].prio;
            run_row(0, 400, 0, -1, 4'h0, base, mdb, st);
            check_row(0, $sformatf("directed%0d", i), base, mdb, st, '0, 0, 1, {cs[i].c, cs[i].p, cs[i].s});
        end
    endtask

    task automatic test_layer_en_mid_row();
        int base, mdb, st;
        fill_random(0);
        len_a = 3'b111; prio_a = 2'd1;
        run_row(0, 400, 0, 100, 4'h0, base, mdb, st);
        check_row(0, "layer_en_toggle", base, mdb, st, 4'h7, 1, 0, '0);
        run_row(0, 400, 0, -1, 4'h0, base, mdb, st);
        check_row(0, "layer_en_zero", base, mdb, st, '0, 0, 1, 10'h000);
        len_a = 3'b111;
    endtask

    task automatic test_reset_mid_row();
        int base, mdb, st;
        bit found = 0;
        fill_random(0);
        len_a = 3'b111; prio_a = 2'd2;
        @(negedge clk);
        done_a = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (wr_en_a && wr_addr_a == 9'd150) begin found = 1; break; end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL reset_mid_wait: column 150 write not seen within 400 cycles");
        end
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset_async");
        base = wq_a.size();
        done_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (wq_a.size() != base) begin
            miscompares++;
            $display("FAIL reset_abandon: got %0d extra writes want 0", wq_a.size() - base);
        end
        run_row(0, 400, 0, -1, 4'h0, base, mdb, st);
        check_row(0, "after_reset_row", base, mdb, st, 4'h7, 2, 0, '0);
    endtask

    task automatic test_small_config();
        int base, mdb, st, pr;
        logic [3:0] m;
        for (int r = 0; r < 4; r++) begin
            fill_random(1);
            pr = (r == 0) ? 3 : $urandom_range(0, 3);
            m = (r < 2) ? 4'hF : 4'($urandom);
            len_b = m; prio_b = 2'(pr);
            run_row(1, 40, 0, -1, 4'h0, base, mdb, st);
            check_row(1, $sformatf("small_row%0d", r), base, mdb, st, m, pr, 0, '0);
        end
        for (int k = 0; k < 8; k++) begin
            tmem_b[k] = {8'h63, 8'h29, 8'h17};
            smem_b[k] = 8'h5C;
        end
        len_b = 4'hF; prio_b = 2'd3;
        run_row(1, 40, 0, -1, 4'h0, base, mdb, st);
        check_row(1, "small_sprite_front", base, mdb, st, '0, 0, 1, {4'hC, 4'h5, 2'd3});
        prio_b = 2'd2;
        run_row(1, 40, 0, -1, 4'h0, base, mdb, st);
        check_row(1, "small_tile2_front", base, mdb, st, '0, 0, 1, {4'h3, 4'h6, 2'd2});
    endtask

    initial begin
        for (int k = 0; k < 320; k++) begin tmem_a[k] = '0; smem_a[k] = '0; end
        for (int k = 0; k < 8; k++) begin tmem_b[k] = '0; smem_b[k] = '0; end
        test_reset();
        test_full_row_hold();
        test_random_rows();
        test_priority_directed();
        test_layer_en_mid_row();
        test_reset_mid_row();
        test_small_config();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_mixer_n.md
PIXEL_MIXER_N -- requirements
Module: pixel_mixer_n

Interface
REQ-001 SHALL have parameter NUM_TILE_LAYERS, default 2, the number of tile pixel engines (range 1-7).
REQ-002 SHALL have parameter ROW_PIXELS, default 320, the pixels per row (range 2-1024).
REQ-003 SHALL have parameter COLOR_W, default 4, the color index width.
REQ-004 SHALL have parameter PAL_W, default 4, the palette index width.
REQ-005 SHALL use the derived widths AW=clog2(ROW_PIXELS), PW=COLOR_W+PAL_W and SW=clog2(NUM_TILE_LAYERS+1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-008 SHALL have port done, input, 1 bit: all pixel engines are ready for the row.
REQ-009 SHALL have port layer_en, input, NUM_TILE_LAYERS+1 bits: per-layer enable, with the MSB being the sprite layer.
REQ-010 SHALL have port pixel_addr, output, AW bits: the column requested from the engines.
REQ-011 SHALL have port tile_pixel_data, input, NUM_TILE_LAYERS*PW bits: layer i occupies bits [i*PW +: PW], as {palette, color}.
REQ-012 SHALL have port sp_pixel_data, input, PW bits: the sprite pixel as {palette, color}.
REQ-013 SHALL have port sp_prio, input, SW bits: the sprite insertion level.
REQ-014 SHALL have port rb_wr_en, output, 1 bit: the rowbuffer write strobe.
REQ-015 SHALL have port rb_wr_addr, output, AW bits: the rowbuffer column.
REQ-016 SHALL have port rb_wr_data, output, PW+SW bits: {color, palette, source}.
REQ-017 SHALL have port mix_done, output, 1 bit: a one-cycle pulse when the last pixel of the row is written.

Function
REQ-018 SHALL implement states IDLE, SWEEP, DRAIN and WAIT_LOW.
REQ-019 SHALL, in IDLE with done=1, capture layer_en into an internal mask, drive pixel_addr=0 and enter SWEEP.
REQ-020 SHALL, in SWEEP, increment pixel_addr by 1 per cycle.
REQ-021 SHALL, in SWEEP after issuing address ROW_PIXELS-1, hold pixel_addr at ROW_PIXELS-1 and enter DRAIN.
REQ-022 SHALL treat engine data as valid the cycle after its address is issued.
REQ-023 SHALL register the write for address k two cycles after k is issued, so the write latency is exactly 2 cycles.
REQ-024 SHALL assert rb_wr_en for exactly ROW_PIXELS consecutive cycles per row, with rb_wr_addr running 0..ROW_PIXELS-1 in order and no gaps or duplicates.
REQ-025 SHALL leave DRAIN once the final write is issued, pulse mix_done in that same cycle, and enter WAIT_LOW.
REQ-026 SHALL stay in WAIT_LOW until done=0, then return to IDLE, so a level-held done never retriggers a row.
REQ-027 SHALL ignore done changes in SWEEP and DRAIN; the row always completes.
REQ-028 SHALL ignore layer_en changes after capture until the next row.
REQ-029 SHALL treat a layer pixel as opaque only if its color is nonzero and its captured mask bit is 1.
REQ-030 SHALL rank tile layer i at level i, with higher levels in front.
REQ-031 SHALL insert the sprite directly behind tile layer sp_prio, so that sp_prio=0 is behind every layer and sp_prio>=NUM_TILE_LAYERS is in front of all.
REQ-032 SHALL select the frontmost opaque pixel; source = its layer index for a tile layer, or NUM_TILE_LAYERS for the sprite.
REQ-033 SHALL, when no pixel is opaque, write the backdrop color=0, palette=0, source=0.
REQ-034 SHALL use only the selected layer's own palette field, with no arithmetic across layers.
REQ-035 SHALL pass through the combinational priority path without registering it except at the outputs.

Reset
REQ-036 SHALL, while rst_n=0, force state=IDLE, pixel_addr=0, rb_wr_en=0, rb_wr_addr=0, rb_wr_data=0, mix_done=0 and mask=0.
REQ-037 SHALL, on reset mid-sweep, abandon the row with no further writes; the first row after reset starts at column 0.
REQ-038 SHALL require done to be sampled high in IDLE after reset release before any activity.

Verification
REQ-039 SHALL cover: defaults, done held high 400 cycles -> exactly 320 writes at addresses 0..319 starting 2 cycles after SWEEP entry, one mix_done pulse, no second row until done falls and rises again.
REQ-040 SHALL cover: tile0=0x35, tile1=0x00, sprite=0x7A, sp_prio=1, all enabled -> wr_data color=0xA, palette=0x7, source=2; same with sp_prio=2 and tile1=0x12 -> sprite still wins.
REQ-041 SHALL cover: tile1=0x12, sprite=0x7A, sp_prio=1 -> color=0x2, palette=0x1, source=1.
REQ-042 SHALL cover: all layers color 0, or layer_en=0 -> data 0; also layer_en toggled mid-row -> output unaffected until next row.
REQ-043 SHALL cover: rst_n pulsed low at column 150 -> outputs zero immediately (asynchronously), no write to 151, next row begins at 0.
REQ-044 SHALL cover: NUM_TILE_LAYERS=3, ROW_PIXELS=8 -> 8 writes, SW=2, and sp_prio=3 places the sprite frontmost.
